// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
package tt_pkg;

    localparam int MAX_IN  = 8;
    localparam int MAX_OUT = 8;
    localparam int MAX_TBL = (1 << MAX_IN) * MAX_OUT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of input vectors in an exhaustive sweep.
    function automatic int vec_count(input int n_in);
        return 1 << n_in;
    endfunction

    // Golden output for vector v, zero-extended to MAX_OUT bits.
    function automatic logic [MAX_OUT-1:0] expected_slice(
        input logic [MAX_TBL-1:0] tbl,
        input int                 n_out,
        input int                 v
    );
        logic [MAX_OUT-1:0] mask;
        mask = MAX_OUT'((1 << n_out) - 1);
        return MAX_OUT'(tbl >> (v * n_out)) & mask;
    endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// Bus between the sweep checker and the logic that starts it / the DUT it probes.
interface truth_table_checker_if #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1
) ();
    logic              start;
    logic [N_IN-1:0]   stimulus;
    logic [N_OUT-1:0]  dut_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_count;
    logic              first_fail_valid;
    logic [N_IN-1:0]   first_fail_vec;

    // Controller side: requests sweeps, feeds DUT outputs back, reads results.
    modport master (
        output start, dut_out,
        input  stimulus, busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );

    // Checker side.
    modport slave (
        input  start, dut_out,
        output stimulus, busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );
endinterface

// File: rtl/settle_timer.sv
// Per-vector settle down-counter; tc marks the final cycle a vector is held.
module settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] count_reg;

    assign tc = (count_reg == '0);

    // Load at sweep start, count down while enabled, reload after each terminal count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= RELOAD;
        end else if (en) begin
            count_reg <= tc ? RELOAD : count_reg - 1'b1;
        end
    end

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive sweep of a combinational DUT against a golden truth table.
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int                              N_IN          = 3,
    parameter int                              N_OUT         = 1,
    parameter logic [(1 << N_IN)*N_OUT-1:0]    EXPECTED      = '0,
    parameter int                              SETTLE_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    truth_table_checker_if.slave bus
);
    localparam int                N_VEC    = vec_count(N_IN);
    localparam logic [N_IN-1:0]   LAST_VEC = N_IN'(N_VEC - 1);
    localparam logic [MAX_TBL-1:0] TBL_EXT = MAX_TBL'(EXPECTED);

    state_t            state_reg;
    logic [N_IN-1:0]   stim_reg;
    logic [N_IN:0]     err_reg;
    logic              ffv_reg;
    logic [N_IN-1:0]   ffvec_reg;

    logic              accept;
    logic              tc;
    logic              mismatch;
    logic [MAX_OUT-1:0] exp_slice;
    logic [MAX_OUT-1:0] obs_ext;

    // start is only honoured when no sweep is running.
    assign accept    = (state_reg != APPLY) && bus.start;
    assign exp_slice = expected_slice(TBL_EXT, N_OUT, int'(stim_reg));
    assign obs_ext   = MAX_OUT'(bus.dut_out);
    assign mismatch  = (exp_slice != obs_ext);

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .en    (state_reg == APPLY),
        .tc    (tc)
    );

    // Sweep sequencer: accept start, step vectors on tc, record mismatches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            stim_reg  <= '0;
            err_reg   <= '0;
            ffv_reg   <= 1'b0;
            ffvec_reg <= '0;
        end else begin
            case (state_reg)
                APPLY: begin
                    if (tc) begin
                        if (mismatch) begin
                            err_reg <= err_reg + 1'b1;
                            if (!ffv_reg) begin
                                ffv_reg   <= 1'b1;
                                ffvec_reg <= stim_reg;
                            end
                        end
                        if (stim_reg == LAST_VEC) begin
                            state_reg <= DONE;
                        end else begin
                            stim_reg <= stim_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    if (accept) begin
                        state_reg <= APPLY;
                        stim_reg  <= '0;
                        err_reg   <= '0;
                        ffv_reg   <= 1'b0;
                        ffvec_reg <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.stimulus         = stim_reg;
    assign bus.busy             = (state_reg == APPLY);
    assign bus.done             = (state_reg == DONE);
    assign bus.pass             = (state_reg == DONE) && (err_reg == '0);
    assign bus.err_count        = err_reg;
    assign bus.first_fail_valid = ffv_reg;
    assign bus.first_fail_vec   = ffvec_reg;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench: two checker configurations (majority, half adder) driven against faultable bench DUTs.
module tb_truth_table_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    truth_table_checker_if #(.N_IN(3), .N_OUT(1)) if_a ();
    truth_table_checker_if #(.N_IN(2), .N_OUT(2)) if_b ();

    truth_table_checker #(
        .N_IN(3), .N_OUT(1), .EXPECTED(8'b1110_1000), .SETTLE_CYCLES(2)
    ) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    truth_table_checker #(
        .N_IN(2), .N_OUT(2), .EXPECTED(8'b10_01_01_00), .SETTLE_CYCLES(1)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    // Fault controls for the bench DUTs.
    logic       stuck_a = 1'b0;
    logic [7:0] flip_a  = 8'h00;
    logic       glitch_a = 1'b0;
    logic [1:0] flip_b [4];

    // Bench DUT A: gate-level majority with optional faults.
    always_comb begin
        logic m;
        m = (if_a.stimulus[2] & if_a.stimulus[1]) |
            (if_a.stimulus[2] & if_a.stimulus[0]) |
            (if_a.stimulus[1] & if_a.stimulus[0]);
        if (stuck_a)
            m = 1'b0;
        else
            m = m ^ flip_a[if_a.stimulus];
        if (glitch_a)
            m = ~m;
        if_a.dut_out = m;
    end

    // Bench DUT B: half adder {carry, sum} with optional per-vector flips.
    always_comb begin
        if_b.dut_out = {if_b.stimulus[1] & if_b.stimulus[0],
                        if_b.stimulus[1] ^ if_b.stimulus[0]} ^ flip_b[if_b.stimulus];
    end

    // Observation mux selected by the running scenario.
    int          sel = 0;
    logic [31:0] obs_stim, obs_busy, obs_done, obs_pass, obs_err, obs_ffv, obs_ffvec;

    always_comb begin
        if (sel == 0) begin
            obs_stim  = 32'(if_a.stimulus);
            obs_busy  = 32'(if_a.busy);
            obs_done  = 32'(if_a.done);
            obs_pass  = 32'(if_a.pass);
            obs_err   = 32'(if_a.err_count);
            obs_ffv   = 32'(if_a.first_fail_valid);
            obs_ffvec = 32'(if_a.first_fail_vec);
        end else begin
            obs_stim  = 32'(if_b.stimulus);
            obs_busy  = 32'(if_b.busy);
            obs_done  = 32'(if_b.done);
            obs_pass  = 32'(if_b.pass);
            obs_err   = 32'(if_b.err_count);
            obs_ffv   = 32'(if_b.first_fail_valid);
            obs_ffvec = 32'(if_b.first_fail_vec);
        end
    end

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: the intended function of each configuration, from arithmetic.
    function automatic int ref_out(input int s, input int v);
        int a, b, c;
        if (s == 0) begin
            a = (v >> 2) & 1; b = (v >> 1) & 1; c = v & 1;
            return ((a + b + c) >= 2) ? 1 : 0;
        end
        a = (v >> 1) & 1; b = v & 1;
        return a + b;
    endfunction

    // What the faulted bench DUT actually produces for vector v.
    function automatic int faulty_out(input int s, input int v);
        if (s == 0)
            return stuck_a ? 0 : (ref_out(0, v) ^ int'(flip_a[v]));
        return ref_out(1, v) ^ int'(flip_b[v]);
    endfunction

    task automatic set_start(input int s, input logic val);
        if (s == 0) if_a.start = val;
        else        if_b.start = val;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_rst_stim"},  obs_stim,  0);
        check({pfx, "_rst_busy"},  obs_busy,  0);
        check({pfx, "_rst_done"},  obs_done,  0);
        check({pfx, "_rst_pass"},  obs_pass,  0);
        check({pfx, "_rst_err"},   obs_err,   0);
        check({pfx, "_rst_ffv"},   obs_ffv,   0);
        check({pfx, "_rst_ffvec"}, obs_ffvec, 0);
    endtask

    // One full sweep; poke_at re-asserts start mid-sweep, reset_at aborts with reset.
    task automatic run_sweep(input int s, input int poke_at, input int reset_at, input bit glitch);
        int n, st, exp_err, exp_first;
        bit exp_ffv;
        sel = s;
        n  = (s == 0) ? 8 : 4;
        st = (s == 0) ? 2 : 1;
        exp_err = 0; exp_first = 0; exp_ffv = 0;
        for (int v = 0; v < n; v++) begin
            if (faulty_out(s, v) != ref_out(s, v)) begin
                exp_err++;
                if (!exp_ffv) begin
                    exp_ffv   = 1;
                    exp_first = v;
                end
            end
        end

        @(negedge clk);
        set_start(s, 1'b1);
        @(posedge clk); #1;
        set_start(s, 1'b0);
        check("accept_err_clr", obs_err, 0);
        check("accept_ffv_clr", obs_ffv, 0);

        for (int c = 0; c < n * st; c++) begin
            if (c == reset_at) begin
                glitch_a = 1'b0;
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                check_zero("midsweep");
                $display("sweep sel=%0d aborted by reset at cycle %0d", s, c);
                return;
            end
            check("sweep_stim", obs_stim, 32'(c / st));
            check("sweep_busy", obs_busy, 1);
            check("sweep_done_early", obs_done, 0);
            glitch_a = (s == 0) && glitch && ((c % st) != (st - 1));
            set_start(s, c == poke_at);
            @(posedge clk); #1;
        end
        glitch_a = 1'b0;
        set_start(s, 1'b0);

        check("end_done",  obs_done,  1);
        check("end_busy",  obs_busy,  0);
        check("end_pass",  obs_pass,  32'(exp_err == 0));
        check("end_err",   obs_err,   32'(exp_err));
        check("end_ffv",   obs_ffv,   32'(exp_ffv));
        check("end_ffvec", obs_ffvec, 32'(exp_first));
        check("end_stim",  obs_stim,  32'(n - 1));
        $display("sweep sel=%0d err=%0d first_valid=%0d first=%0d pass=%0d",
                 s, obs_err, obs_ffv, obs_ffvec, obs_pass);
    endtask

    initial begin
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        for (int i = 0; i < 4; i++) flip_b[i] = 2'b00;

        // Reset state of both checkers.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sel = 0; #1; check_zero("a");
        sel = 1; #1; check_zero("b");
        rst_n = 1'b1;

        // Correct majority DUT, with glitches during non-sampling cycles.
        run_sweep(0, -1, -1, 1'b1);

        // Stuck-at-0 output.
        stuck_a = 1'b1;
        run_sweep(0, -1, -1, 1'b0);

        // Results held in DONE.
        repeat (3) @(posedge clk);
        #1;
        check("hold_done",  obs_done,  1);
        check("hold_err",   obs_err,   4);
        check("hold_ffvec", obs_ffvec, 3);
        check("hold_pass",  obs_pass,  0);

        // Restart from DONE with the correct DUT.
        stuck_a = 1'b0;
        run_sweep(0, -1, -1, 1'b0);

        // start during APPLY is ignored.
        stuck_a = 1'b1;
        run_sweep(0, 5, -1, 1'b0);
        stuck_a = 1'b0;

        // Reset mid-sweep, then a clean sweep.
        run_sweep(0, -1, 9, 1'b0);
        run_sweep(0, -1, -1, 1'b1);

        // Random fault masks on the majority DUT.
        for (int k = 0; k < 4; k++) begin
            flip_a = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_sweep(0, (k == 1) ? int'($urandom_range(0, 15)) : -1, -1, 1'b1);
        end
        flip_a = 8'h00;

        // Half adder: correct, then sum flipped for vector 2 only.
        run_sweep(1, -1, -1, 1'b0);
        flip_b[2] = 2'b01;
        run_sweep(1, -1, -1, 1'b0);

        // Random per-vector flips on the half adder.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) flip_b[i] = 2'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_sweep(1, -1, -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
